entrada_monto: RTL and testbench
================================

ENTRADA_MONTO -- requirements
Module: entrada_monto

Interface
REQ-001 Parameter MAX_DIGITOS, default 9, maximum decimal digits accepted per amount.
REQ-002 Parameter TIMEOUT_CICLOS, default 1000, idle clock cycles in capture before the entry is abandoned.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 habilitar  input  1  amount entry requested by the ATM controller; level.
REQ-006 tecla  input  4  key code; valid only while tecla_stb=1.
REQ-007 tecla_stb  input  1  one-cycle key strobe, synchronous to clk.
REQ-008 monto  output  32  binary amount delivered to the controller; registered.
REQ-009 monto_stb  output  1  one-cycle pulse, monto valid.
REQ-010 digitos  output  4  digits currently captured.
REQ-011 error_formato  output  1  one-cycle pulse, rejected key.
REQ-012 tiempo_agotado  output  1  one-cycle pulse, capture abandoned by timeout.

Function
REQ-013 Key map SHALL be: 0x0-0x9 digit, 0xA borrar (clear), 0xB aceptar (enter), 0xC-0xF ignored with no effect.
REQ-014 FSM states SHALL be INACTIVO, CAPTURA, ESPERA_BAJA; all outputs registered.
REQ-015 INACTIVO: accumulator=0, digitos=0, keys ignored; habilitar=1 -> CAPTURA next edge.
REQ-016 CAPTURA, digit key with digitos<MAX_DIGITOS: accumulator <= accumulator*10 + tecla, digitos+1; leading zeros count as digits.
REQ-017 CAPTURA, digit key with digitos==MAX_DIGITOS: key dropped, error_formato=1 for one cycle, accumulator unchanged.
REQ-018 CAPTURA, borrar: accumulator=0, digitos=0, stay CAPTURA, no error.
REQ-019 CAPTURA, aceptar with digitos>0: at that same edge monto<=accumulator, monto_stb=1 for exactly one cycle, go ESPERA_BAJA.
REQ-020 CAPTURA, aceptar with digitos==0: error_formato=1 one cycle, monto/monto_stb unchanged, stay CAPTURA.
REQ-021 Multiply-by-10 SHALL be computed as (acc<<3)+(acc<<1) in 32 bits; with MAX_DIGITOS<=9 no overflow occurs (max 999999999).
REQ-022 Timeout counter SHALL clear on entry to CAPTURA and on every tecla_stb in CAPTURA, else increment.
REQ-023 Counter reaching TIMEOUT_CICLOS with no tecla_stb that cycle: tiempo_agotado=1 one cycle, accumulator/digitos cleared, go INACTIVO; reentry requires habilitar low then high.
REQ-024 tecla_stb in the same cycle as timeout expiry: key wins, counter clears, no timeout.
REQ-025 habilitar=0 in CAPTURA: go INACTIVO next edge, accumulator cleared, any key that cycle dropped, no monto_stb, no error.
REQ-026 ESPERA_BAJA: keys ignored; stay until habilitar=0, then INACTIVO; prevents a second amount in one transaction.
REQ-027 After timeout, INACTIVO SHALL NOT reenter CAPTURA until habilitar observed low for at least one cycle.
REQ-028 monto SHALL hold its last delivered value until the next aceptar or reset.
REQ-029 digitos SHALL reflect the digit count in CAPTURA and be 0 in INACTIVO.

Reset
REQ-030 rst=0 at a rising edge: state INACTIVO, monto=0, monto_stb=0, digitos=0, error_formato=0, tiempo_agotado=0, accumulator=0, timeout counter=0.
REQ-031 Reset mid-capture or in the cycle of aceptar SHALL suppress monto_stb and discard the partial amount.
REQ-032 Reset SHALL override every other input in the same cycle.

Verification
REQ-033 habilitar=1; keys 1,2,5,0,B -> monto=1250 (0x000004E2), monto_stb high exactly one cycle at the B edge, state ESPERA_BAJA.
REQ-034 Keys 7,A,3,B -> monto=3; after A, digitos=0; no error_formato.
REQ-035 Ten keys 9 then B -> tenth 9 raises error_formato one cycle; monto=999999999 (0x3B9AC9FF).
REQ-036 B with no digits -> error_formato one cycle, no monto_stb; then 4,B -> monto=4.
REQ-037 Key 5, then 1000 idle cycles -> tiempo_agotado one cycle, INACTIVO, digitos=0; key arriving on expiry cycle instead keeps CAPTURA.
REQ-038 rst=0 one cycle after keys 8,8 -> all outputs 0, no monto_stb; drop habilitar in CAPTURA -> INACTIVO, no pulses.

Source files
------------

// File: rtl/entrada_monto_if.sv
// Keypad amount-entry bus between the ATM controller (master) and entrada_monto (slave).
interface entrada_monto_if;
    logic        habilitar;
    logic [3:0]  tecla;
    logic        tecla_stb;
    logic [31:0] monto;
    logic        monto_stb;
    logic [3:0]  digitos;
    logic        error_formato;
    logic        tiempo_agotado;

    modport master (
        output habilitar, tecla, tecla_stb,
        input  monto, monto_stb, digitos, error_formato, tiempo_agotado
    );

    modport slave (
        input  habilitar, tecla, tecla_stb,
        output monto, monto_stb, digitos, error_formato, tiempo_agotado
    );
endinterface

// File: rtl/entrada_monto.sv
// Decimal amount capture from a keypad: accumulates digits, delivers a binary amount
// on enter, with clear, digit limit, idle timeout and one amount per transaction.
module entrada_monto #(
    parameter int unsigned MAX_DIGITOS    = 9,
    parameter int unsigned TIMEOUT_CICLOS = 1000
) (
    input logic            clk,
    input logic            rst,
    entrada_monto_if.slave bus
);
    localparam int unsigned   CW    = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [3:0]    MAX_D = 4'(MAX_DIGITOS);
    localparam logic [CW-1:0] LIM   = CW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [1:0] {
        INACTIVO    = 2'd0,
        CAPTURA     = 2'd1,
        ESPERA_BAJA = 2'd2
    } estado_t;

    estado_t       estado, estado_sig;
    logic [31:0]   acc, acc_sig;
    logic [3:0]    dig, dig_sig;
    logic [CW-1:0] cnt, cnt_sig;
    logic [31:0]   monto_r, monto_sig;
    logic          stb_r, stb_sig;
    logic          err_r, err_sig;
    logic          to_r, to_sig;
    // Set by a timeout; blocks reentry until habilitar has been seen low.
    logic          bloq, bloq_sig;

    always_ff @(posedge clk) begin
        if (!rst) begin
            estado  <= INACTIVO;
            acc     <= '0;
            dig     <= '0;
            cnt     <= '0;
            monto_r <= '0;
            stb_r   <= 1'b0;
            err_r   <= 1'b0;
            to_r    <= 1'b0;
            bloq    <= 1'b0;
        end else begin
            estado  <= estado_sig;
            acc     <= acc_sig;
            dig     <= dig_sig;
            cnt     <= cnt_sig;
            monto_r <= monto_sig;
            stb_r   <= stb_sig;
            err_r   <= err_sig;
            to_r    <= to_sig;
            bloq    <= bloq_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        acc_sig    = acc;
        dig_sig    = dig;
        cnt_sig    = cnt;
        monto_sig  = monto_r;
        stb_sig    = 1'b0;
        err_sig    = 1'b0;
        to_sig     = 1'b0;
        bloq_sig   = bloq;

        unique case (estado)
            INACTIVO: begin
                acc_sig = '0;
                dig_sig = '0;
                cnt_sig = '0;
                if (!bus.habilitar)
                    bloq_sig = 1'b0;
                else if (!bloq)
                    estado_sig = CAPTURA;
            end

            CAPTURA: begin
                if (!bus.habilitar) begin
                    estado_sig = INACTIVO;
                    acc_sig    = '0;
                    dig_sig    = '0;
                    cnt_sig    = '0;
                end else if (bus.tecla_stb) begin
                    // A key always restarts the idle count, even on the expiry cycle.
                    cnt_sig = '0;
                    if (bus.tecla <= 4'd9) begin
                        if (dig < MAX_D) begin
                            acc_sig = (acc << 3) + (acc << 1) + {28'd0, bus.tecla};
                            dig_sig = dig + 4'd1;
                        end else begin
                            err_sig = 1'b1;
                        end
                    end else if (bus.tecla == 4'hA) begin
                        acc_sig = '0;
                        dig_sig = '0;
                    end else if (bus.tecla == 4'hB) begin
                        if (dig != 4'd0) begin
                            monto_sig  = acc;
                            stb_sig    = 1'b1;
                            acc_sig    = '0;
                            dig_sig    = '0;
                            estado_sig = ESPERA_BAJA;
                        end else begin
                            err_sig = 1'b1;
                        end
                    end
                end else if (cnt == LIM) begin
                    to_sig     = 1'b1;
                    acc_sig    = '0;
                    dig_sig    = '0;
                    cnt_sig    = '0;
                    bloq_sig   = 1'b1;
                    estado_sig = INACTIVO;
                end else begin
                    cnt_sig = cnt + 1'b1;
                end
            end

            ESPERA_BAJA: begin
                cnt_sig = '0;
                if (!bus.habilitar)
                    estado_sig = INACTIVO;
            end

            default: estado_sig = INACTIVO;
        endcase
    end

    assign bus.monto          = monto_r;
    assign bus.monto_stb      = stb_r;
    assign bus.digitos        = dig;
    assign bus.error_formato  = err_r;
    assign bus.tiempo_agotado = to_r;
endmodule

// File: tb/tb_entrada_monto.sv
// Directed bench for entrada_monto: delivered amounts are checked against a
// scoreboard queue, pulses and digit counts against directed expectations.
module tb_entrada_monto;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned n_err = 0;
    int unsigned n_to = 0;
    logic [31:0] sb[$];
    logic [31:0] esperado;

    entrada_monto_if bus();

    entrada_monto #(.MAX_DIGITOS(9), .TIMEOUT_CICLOS(1000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; samples registered outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.error_formato === 1'b1) n_err++;
        if (bus.tiempo_agotado === 1'b1) n_to++;
        if (bus.monto_stb !== 1'b0) begin
            if (sb.size() == 0) begin
                chk("stb_inesperado", 32'(bus.monto_stb), 32'd0);
            end else begin
                esperado = sb.pop_front();
                chk("monto", bus.monto, esperado);
            end
        end
    endtask

    task automatic press(input logic [3:0] k);
        bus.tecla     = k;
        bus.tecla_stb = 1'b1;
        tick();
        bus.tecla_stb = 1'b0;
        bus.tecla     = 4'hF;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    initial begin
        bus.habilitar = 1'b0;
        bus.tecla     = 4'hF;
        bus.tecla_stb = 1'b0;
        rst = 1'b0;
        idle(2);
        chk("rst_monto", bus.monto, 32'd0);
        chk("rst_stb", 32'(bus.monto_stb), 32'd0);
        chk("rst_digitos", 32'(bus.digitos), 32'd0);
        chk("rst_err", 32'(bus.error_formato), 32'd0);
        chk("rst_to", 32'(bus.tiempo_agotado), 32'd0);
        rst = 1'b1;
        idle(1);

        // 1,2,5,0,B -> 1250, single-cycle strobe, then a second amount is ignored
        bus.habilitar = 1'b1;
        idle(1);
        press(4'h1); press(4'h2); press(4'h5); press(4'h0);
        chk("s1_digitos", 32'(bus.digitos), 32'd4);
        sb.push_back(32'd1250);
        press(4'hB);
        chk("s1_stb_alto", 32'(bus.monto_stb), 32'd1);
        idle(1);
        chk("s1_stb_bajo", 32'(bus.monto_stb), 32'd0);
        chk("s1_monto_hold", bus.monto, 32'h0000_04E2);
        press(4'h3); press(4'hB);
        chk("s1_espera_err", 32'(n_err), 32'd0);
        bus.habilitar = 1'b0;
        idle(2);

        // 7,A,3,B -> 3
        bus.habilitar = 1'b1;
        idle(1);
        press(4'h7);
        press(4'hA);
        chk("s2_borrar_digitos", 32'(bus.digitos), 32'd0);
        press(4'h3);
        sb.push_back(32'd3);
        press(4'hB);
        chk("s2_sin_err", 32'(n_err), 32'd0);
        bus.habilitar = 1'b0;
        idle(2);

        // ten 9s: the tenth is rejected
        bus.habilitar = 1'b1;
        idle(1);
        for (int i = 0; i < 9; i++) press(4'h9);
        chk("s3_digitos_max", 32'(bus.digitos), 32'd9);
        press(4'h9);
        chk("s3_err_alto", 32'(bus.error_formato), 32'd1);
        idle(1);
        chk("s3_err_bajo", 32'(bus.error_formato), 32'd0);
        chk("s3_digitos", 32'(bus.digitos), 32'd9);
        sb.push_back(32'h3B9A_C9FF);
        press(4'hB);
        bus.habilitar = 1'b0;
        idle(2);

        // enter with no digits
        bus.habilitar = 1'b1;
        idle(1);
        press(4'hC);
        chk("s4_tecla_ignorada", 32'(bus.digitos), 32'd0);
        press(4'hB);
        chk("s4_err", 32'(bus.error_formato), 32'd1);
        chk("s4_monto_hold", bus.monto, 32'h3B9A_C9FF);
        press(4'h4);
        sb.push_back(32'd4);
        press(4'hB);
        chk("s4_err_total", 32'(n_err), 32'd2);
        bus.habilitar = 1'b0;
        idle(2);

        // timeout after 1000 idle cycles, then blocked until habilitar drops
        bus.habilitar = 1'b1;
        idle(1);
        press(4'h5);
        idle(999);
        chk("s5_antes_to", 32'(n_to), 32'd0);
        chk("s5_digitos_antes", 32'(bus.digitos), 32'd1);
        idle(1);
        chk("s5_to_alto", 32'(bus.tiempo_agotado), 32'd1);
        chk("s5_digitos_to", 32'(bus.digitos), 32'd0);
        idle(1);
        chk("s5_to_bajo", 32'(bus.tiempo_agotado), 32'd0);
        press(4'h6);
        chk("s5_bloqueado", 32'(bus.digitos), 32'd0);
        bus.habilitar = 1'b0;
        idle(1);
        bus.habilitar = 1'b1;
        idle(1);
        press(4'h2);
        chk("s5_reentrada", 32'(bus.digitos), 32'd1);
        idle(999);
        press(4'h7);
        chk("s5_tecla_gana", 32'(n_to), 32'd1);
        chk("s5_tecla_digitos", 32'(bus.digitos), 32'd2);
        sb.push_back(32'd27);
        press(4'hB);
        bus.habilitar = 1'b0;
        idle(2);

        // reset in the cycle of enter discards the amount
        bus.habilitar = 1'b1;
        idle(1);
        press(4'h8); press(4'h8);
        rst = 1'b0;
        press(4'hB);
        chk("s6_rst_monto", bus.monto, 32'd0);
        chk("s6_rst_digitos", 32'(bus.digitos), 32'd0);
        chk("s6_rst_stb", 32'(bus.monto_stb), 32'd0);
        rst = 1'b1;
        idle(1);
        press(4'h4);
        chk("s6_captura", 32'(bus.digitos), 32'd1);

        // habilitar drop with a key in the same cycle
        bus.habilitar = 1'b0;
        press(4'h5);
        chk("s6_baja_digitos", 32'(bus.digitos), 32'd0);
        chk("s6_baja_err", 32'(bus.error_formato), 32'd0);
        bus.habilitar = 1'b1;
        idle(1);
        press(4'hB);
        chk("s6_acc_vacio", 32'(bus.error_formato), 32'd1);
        bus.habilitar = 1'b0;
        idle(2);

        chk("sb_vacio", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
